// File: rtl/alu_pipe.sv
// alu_pipe: pipelined execute-stage ALU with valid/ready slots, tag pass-through and flush.
// Defining ALU_PIPE_OVF_EN compiles in the pipelined signed-overflow flag for ADD/SUB.

`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef ALUOP_WIDTH
`define ALUOP_WIDTH 5
`endif
`ifndef ALU_SRC_WIDTH
`define ALU_SRC_WIDTH 3
`endif

`ifndef ALU_ADD
`define ALU_ADD      5'd0
`define ALU_SUB      5'd1
`define ALU_LOGIC_SL 5'd2
`define ALU_LOGIC_SR 5'd3
`define ALU_ARITH_SR 5'd4
`define ALU_AND      5'd5
`define ALU_OR       5'd6
`define ALU_XOR      5'd7
`define ALU_NOR      5'd8
`define ALU_EQ       5'd9
`define ALU_NEQ      5'd10
`define ALU_G        5'd11
`define ALU_L        5'd12
`define ALU_GE       5'd13
`define ALU_LE       5'd14
`define ALU_G_U      5'd15
`define ALU_L_U      5'd16
`define ALU_GE_U     5'd17
`define ALU_LE_U     5'd18
`endif

`ifndef ALU_OP_SRC_ZERO
`define ALU_OP_SRC_ZERO 3'd0
`define ALU_OP_SRC_IMM  3'd1
`define ALU_OP_SRC_RS   3'd2
`define ALU_OP_SRC_RT   3'd3
`define ALU_OP_SRC_PC   3'd4
`endif

module alu_pipe #(
  parameter int unsigned W      = `WORD_WIDTH,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [`ALUOP_WIDTH-1:0]   alu_op,
  input  logic [`ALU_SRC_WIDTH-1:0] alu_op1_src,
  input  logic [`ALU_SRC_WIDTH-1:0] alu_op2_src,
  input  logic [W-1:0]              rs_val,
  input  logic [W-1:0]              rt_val,
  input  logic [W-1:0]              imm,
  input  logic [W-1:0]              pc,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [W-1:0]              result,
  output logic [TAG_W-1:0]          out_tag,
  output logic                      ovf
);

  localparam int unsigned SH_W = $clog2(W);

  logic [W-1:0]    op1, op2;
  logic [SH_W-1:0] sh;
  logic [W-1:0]    res_c;

  // Operand muxes; unknown source codes read as zero.
  function automatic logic [W-1:0] pick(input logic [`ALU_SRC_WIDTH-1:0] src,
                                        input logic [W-1:0] rs, input logic [W-1:0] rt,
                                        input logic [W-1:0] im, input logic [W-1:0] p);
    logic [W-1:0] v;
    v = '0;
    case (src)
      `ALU_OP_SRC_IMM: v = im;
      `ALU_OP_SRC_RS:  v = rs;
      `ALU_OP_SRC_RT:  v = rt;
      `ALU_OP_SRC_PC:  v = p;
      default:         v = '0;
    endcase
    return v;
  endfunction

  assign op1 = pick(alu_op1_src, rs_val, rt_val, imm, pc);
  assign op2 = pick(alu_op2_src, rs_val, rt_val, imm, pc);
  assign sh  = op2[SH_W-1:0];

`ifdef ALU_PIPE_OVF_EN
  logic [W:0] add_x, sub_x;
  logic       ovf_c;
  assign add_x = {op1[W-1], op1} + {op2[W-1], op2};
  assign sub_x = {op1[W-1], op1} - {op2[W-1], op2};
`endif

  always_comb begin
    res_c = '0;
`ifdef ALU_PIPE_OVF_EN
    ovf_c = 1'b0;
`endif
    case (alu_op)
`ifdef ALU_PIPE_OVF_EN
      `ALU_ADD:      begin res_c = add_x[W-1:0]; ovf_c = add_x[W] ^ add_x[W-1]; end
      `ALU_SUB:      begin res_c = sub_x[W-1:0]; ovf_c = sub_x[W] ^ sub_x[W-1]; end
`else
      `ALU_ADD:      res_c = op1 + op2;
      `ALU_SUB:      res_c = op1 - op2;
`endif
      `ALU_LOGIC_SL: res_c = op1 << sh;
      `ALU_LOGIC_SR: res_c = op1 >> sh;
      `ALU_ARITH_SR: res_c = W'($signed(op1) >>> sh);
      `ALU_AND:      res_c = op1 & op2;
      `ALU_OR:       res_c = op1 | op2;
      `ALU_XOR:      res_c = op1 ^ op2;
      `ALU_NOR:      res_c = ~(op1 | op2);
      `ALU_EQ:       res_c = W'(op1 == op2);
      `ALU_NEQ:      res_c = W'(op1 != op2);
      `ALU_G:        res_c = W'($signed(op1) >  $signed(op2));
      `ALU_L:        res_c = W'($signed(op1) <  $signed(op2));
      `ALU_GE:       res_c = W'($signed(op1) >= $signed(op2));
      `ALU_LE:       res_c = W'($signed(op1) <= $signed(op2));
      `ALU_G_U:      res_c = W'(op1 >  op2);
      `ALU_L_U:      res_c = W'(op1 <  op2);
      `ALU_GE_U:     res_c = W'(op1 >= op2);
      `ALU_LE_U:     res_c = W'(op1 <= op2);
      default:       res_c = '0;
    endcase
  end

  logic [STAGES-1:0] v, en, up_v;
  logic [W-1:0]      res_q  [STAGES];
  logic [W-1:0]      up_res [STAGES];
  logic [TAG_W-1:0]  tag_q  [STAGES];
  logic [TAG_W-1:0]  up_tag [STAGES];

  // A slot may load if it or any slot downstream of it has room, or the consumer drains.
  for (genvar g = 0; g < STAGES; g++) begin : g_en
    assign en[g] = out_ready | ~(&v[STAGES-1:g]);
  end

  assign up_v[0]   = in_valid;
  assign up_res[0] = res_c;
  assign up_tag[0] = in_tag;
  for (genvar g = 1; g < STAGES; g++) begin : g_link
    assign up_v[g]   = v[g-1];
    assign up_res[g] = res_q[g-1];
    assign up_tag[g] = tag_q[g-1];
  end

  // Slot registers; flush clears only the valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int i = 0; i < STAGES; i++) begin
        res_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (flush)      v[i] <= 1'b0;
        else if (en[i]) v[i] <= up_v[i];
        if (en[i]) begin
          res_q[i] <= up_res[i];
          tag_q[i] <= up_tag[i];
        end
      end
    end
  end

`ifdef ALU_PIPE_OVF_EN
  logic [STAGES-1:0] ovf_q, up_ovf;
  assign up_ovf[0] = ovf_c;
  for (genvar g = 1; g < STAGES; g++) begin : g_ovf_link
    assign up_ovf[g] = ovf_q[g-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (en[i]) ovf_q[i] <= up_ovf[i];
      end
    end
  end

  assign ovf = ovf_q[STAGES-1];
`else
  assign ovf = 1'b0;
`endif

  assign in_ready  = en[0];
  assign out_valid = v[STAGES-1];
  assign result    = res_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (W=32, STAGES=2); ovf expectations follow ALU_PIPE_OVF_EN.
`timescale 1ns/1ps
module tb_alu_pipe;
  localparam int unsigned W = 32, STAGES = 2, TAG_W = 5;

  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_SLL = 5'd2,  OP_SRL = 5'd3;
  localparam logic [4:0] OP_SRA = 5'd4,  OP_AND = 5'd5,  OP_OR  = 5'd6,  OP_XOR = 5'd7;
  localparam logic [4:0] OP_NOR = 5'd8,  OP_EQ  = 5'd9,  OP_NEQ = 5'd10, OP_G   = 5'd11;
  localparam logic [4:0] OP_L   = 5'd12, OP_GE  = 5'd13, OP_LE  = 5'd14, OP_GU  = 5'd15;
  localparam logic [4:0] OP_LU  = 5'd16, OP_GEU = 5'd17, OP_LEU = 5'd18, OP_BAD = 5'd31;
  localparam logic [2:0] S_ZERO = 3'd0, S_IMM = 3'd1, S_RS = 3'd2, S_RT = 3'd3, S_PC = 3'd4, S_BAD = 3'd7;

  logic             clk = 1'b0;
  logic             rst_n, flush, in_valid, in_ready, out_valid, out_ready, ovf;
  logic [4:0]       alu_op;
  logic [2:0]       alu_op1_src, alu_op2_src;
  logic [W-1:0]     rs_val, rt_val, imm, pc, result;
  logic [TAG_W-1:0] in_tag, out_tag;

  alu_pipe #(.W(W), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .alu_op1_src(alu_op1_src), .alu_op2_src(alu_op2_src),
    .rs_val(rs_val), .rt_val(rt_val), .imm(imm), .pc(pc), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_tag(out_tag), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]     res;
    logic [TAG_W-1:0] tag;
    logic             ovf;
    int               acc;
    bit               lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   pop_cyc[$];
  int   cyc = 0;
  int   n_checks = 0, n_errors = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ovf_exp(input logic o);
`ifdef ALU_PIPE_OVF_EN
    return o;
`else
    return 1'b0 & o;
`endif
  endfunction

  function automatic logic [W-1:0] sel(input logic [2:0] s, input logic [W-1:0] rs, input logic [W-1:0] rt,
                                       input logic [W-1:0] im, input logic [W-1:0] p);
    if (s == S_IMM) return im;
    if (s == S_RS)  return rs;
    if (s == S_RT)  return rt;
    if (s == S_PC)  return p;
    return '0;
  endfunction

  // Reference model: overflow judged from operand and result sign bits.
  function automatic logic [W:0] ref_alu(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic         o;
    r = '0;
    o = 1'b0;
    case (op)
      OP_ADD: begin r = a + b; o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
      OP_SUB: begin r = a - b; o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
      OP_SLL: r = a << b[4:0];
      OP_SRL: r = a >> b[4:0];
      OP_SRA: r = $unsigned($signed(a) >>> b[4:0]);
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOR: r = ~(a | b);
      OP_EQ:  r = {31'd0, a == b};
      OP_NEQ: r = {31'd0, a != b};
      OP_G:   r = {31'd0, $signed(a) >  $signed(b)};
      OP_L:   r = {31'd0, $signed(a) <  $signed(b)};
      OP_GE:  r = {31'd0, $signed(a) >= $signed(b)};
      OP_LE:  r = {31'd0, $signed(a) <= $signed(b)};
      OP_GU:  r = {31'd0, a >  b};
      OP_LU:  r = {31'd0, a <  b};
      OP_GEU: r = {31'd0, a >= b};
      OP_LEU: r = {31'd0, a <= b};
      default: r = '0;
    endcase
    return {o, r};
  endfunction

  task automatic drive(input logic [4:0] op, input logic [2:0] s1, input logic [2:0] s2,
                       input logic [W-1:0] rs, input logic [W-1:0] rt, input logic [W-1:0] im,
                       input logic [W-1:0] p, input logic [TAG_W-1:0] tag);
    alu_op = op; alu_op1_src = s1; alu_op2_src = s2;
    rs_val = rs; rt_val = rt; imm = im; pc = p; in_tag = tag;
    in_valid = 1'b1;
  endtask

  // Called at posedge+1; pushes the expectation on acceptance and returns at posedge+1.
  task automatic issue(input logic [4:0] op, input logic [2:0] s1, input logic [2:0] s2,
                       input logic [W-1:0] rs, input logic [W-1:0] rt, input logic [W-1:0] im,
                       input logic [W-1:0] p, input logic [TAG_W-1:0] tag,
                       input logic [W-1:0] eres, input logic eovf, input bit lat);
    int n;
    exp_t e;
    n = 0;
    drive(op, s1, s2, rs, rt, im, p, tag);
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("issue_timeout", 64'(in_ready), 64'd1);
    else begin
      e.res = eres; e.tag = tag; e.ovf = ovf_exp(eovf); e.acc = cyc; e.lat = lat;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic issue_rand(input logic [TAG_W-1:0] tag);
    logic [4:0]   op;
    logic [2:0]   s1, s2;
    logic [W-1:0] rs, rt, im, p;
    logic [W:0]   r;
    op = ($urandom_range(0, 9) == 0) ? OP_BAD : 5'($urandom_range(0, 18));
    s1 = ($urandom_range(0, 9) == 0) ? S_BAD : 3'($urandom_range(0, 4));
    s2 = 3'($urandom_range(0, 4));
    rs = $urandom; rt = $urandom; im = $urandom; p = $urandom;
    if ($urandom_range(0, 3) == 0) rt = rs;
    r = ref_alu(op, sel(s1, rs, rt, im, p), sel(s2, rs, rt, im, p));
    issue(op, s1, s2, rs, rt, im, p, tag, r[W-1:0], r[W], 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Output monitor: pops and compares on each completed output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) check("spurious_out", 64'd1, 64'd0);
      else begin
        mon_e = sb.pop_front();
        check("result", 64'(result), 64'(mon_e.res));
        check("out_tag", 64'(out_tag), 64'(mon_e.tag));
        check("ovf", 64'(ovf), 64'(mon_e.ovf));
        if (mon_e.lat) check("latency", 64'(cyc - mon_e.acc), 64'(STAGES));
        pop_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(OP_ADD, S_ZERO, S_ZERO, '0, '0, '0, '0, '0);
    in_valid = 1'b0;
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_result", 64'(result), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed ops from the test plan plus operand-source corners.
    issue(OP_ADD, S_RS, S_RT, 32'h7FFF_FFFF, 32'h1, '0, '0, 5'd3, 32'h8000_0000, 1'b1, 1'b1);
    issue(OP_SRA, S_RS, S_IMM, 32'h8000_0000, '0, 32'd33, '0, 5'd4, 32'hC000_0000, 1'b0, 1'b1);
    issue(OP_SRL, S_RS, S_IMM, 32'h8000_0000, '0, 32'd33, '0, 5'd5, 32'h4000_0000, 1'b0, 1'b1);
    issue(OP_L,   S_RS, S_RT, 32'hFFFF_FFFF, 32'h1, '0, '0, 5'd6, 32'h1, 1'b0, 1'b1);
    issue(OP_LU,  S_RS, S_RT, 32'hFFFF_FFFF, 32'h1, '0, '0, 5'd7, 32'h0, 1'b0, 1'b1);
    issue(OP_SUB, S_RT, S_IMM, '0, 32'h8000_0000, 32'h1, '0, 5'd8, 32'h7FFF_FFFF, 1'b1, 1'b1);
    issue(OP_ADD, S_PC, S_ZERO, 32'h5, 32'h6, 32'h7, 32'h0000_1234, 5'd9, 32'h0000_1234, 1'b0, 1'b1);
    issue(OP_ADD, S_BAD, S_BAD, 32'h5, 32'h6, 32'h7, 32'h8, 5'd10, 32'h0, 1'b0, 1'b1);
    issue(OP_BAD, S_RS, S_RT, 32'h7FFF_FFFF, 32'h1, '0, '0, 5'd11, 32'h0, 1'b0, 1'b1);
    issue(OP_NOR, S_RS, S_RT, 32'hF0F0_0000, 32'h0000_000F, '0, '0, 5'd12, 32'h0F0F_FFF0, 1'b0, 1'b1);
    issue(OP_SLL, S_RS, S_IMM, 32'h0000_0003, '0, 32'hFFFF_FFE4, '0, 5'd13, 32'h0000_0030, 1'b0, 1'b1);
    issue(OP_GEU, S_RS, S_RT, 32'h8000_0000, 32'h7FFF_FFFF, '0, '0, 5'd14, 32'h1, 1'b0, 1'b1);
    issue(OP_GE,  S_RS, S_RT, 32'h8000_0000, 32'h7FFF_FFFF, '0, '0, 5'd15, 32'h0, 1'b0, 1'b1);
    issue(OP_ADD, S_RS, S_RT, 32'hFFFF_FFFF, 32'h1, '0, '0, 5'd16, 32'h0, 1'b0, 1'b1);
    drain();

    // Back-pressure: two fill the pipe, the third stalls until out_ready returns.
    out_ready = 1'b0;
    for (int t = 1; t <= 2; t++)
      issue(OP_ADD, S_RS, S_IMM, 32'(t), '0, 32'h100, '0, 5'(t), 32'(t) + 32'h100, 1'b0, 1'b0);
    drive(OP_ADD, S_RS, S_IMM, 32'd3, '0, 32'h100, '0, 5'd3);
    @(negedge clk);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("bp_in_ready_hold", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    check("bp_out_tag", 64'(out_tag), 64'd1);
    @(posedge clk); #1;
    pop_cyc.delete();
    out_ready = 1'b1;
    for (int t = 3; t <= 4; t++)
      issue(OP_ADD, S_RS, S_IMM, 32'(t), '0, 32'h100, '0, 5'(t), 32'(t) + 32'h100, 1'b0, 1'b0);
    drain();
    check("bp_pop_count", 64'(pop_cyc.size()), 64'd4);
    for (int k = 1; k < pop_cyc.size(); k++)
      check("bp_consecutive", 64'(pop_cyc[k] - pop_cyc[k-1]), 64'd1);

    // Flush with two in flight and a third presented on the flush cycle.
    out_ready = 1'b0;
    issue(OP_OR, S_RS, S_RT, 32'hA, 32'h5, '0, '0, 5'd20, 32'hF, 1'b0, 1'b0);
    issue(OP_OR, S_RS, S_RT, 32'hA0, 32'h5, '0, '0, 5'd21, 32'hA5, 1'b0, 1'b0);
    drive(OP_OR, S_RS, S_RT, 32'hB0, 32'h5, '0, '0, 5'd22);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    check("flush_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("flush_quiet", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    issue(OP_XOR, S_RS, S_RT, 32'hFF00_FF00, 32'h0FF0_0FF0, '0, '0, 5'd23, 32'hF0F0_F0F0, 1'b0, 1'b1);
    drain();

    // Random stream, then asynchronous reset while ops are in flight.
    for (int t = 0; t < 24; t++) issue_rand(5'(t));
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_result", 64'(result), 64'd0);
    check("arst_ovf", 64'(ovf), 64'd0);
    check("arst_out_tag", 64'(out_tag), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);
    issue(OP_LE, S_RS, S_RT, 32'hFFFF_FFFE, 32'hFFFF_FFFE, '0, '0, 5'd30, 32'h1, 1'b0, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
